axi_csr_fifo_top_v2: RTL
========================

# axi_csr_fifo_top_v2

Parametrised successor of the AXI4-Lite CSR + FIFO subsystem top. A single AXI4-Lite slave exposes control, status, programmable thresholds, sticky error flags and a data window for push and pop. The FIFO is still reachable through the external wr_en/rd_en port, and an interrupt output is added. It sits between the system interconnect and a streaming producer/consumer.

## Interface
- ADDR_WIDTH, 12, AXI address width (byte addresses; bits [1:0] ignored)
- DATA_WIDTH, 32, AXI and FIFO data width; must be 32 or 64
- FIFO_DEPTH, 16, entries; power of 2, 4..1024
- ACLK  in  1  single system clock; all logic on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave, standard widths (WSTRB = DATA_WIDTH/8; BRESP/RRESP 2)
- wr_en  in  1  external push strobe
- data_in  in  DATA_WIDTH  external push data
- rd_en  in  1  external pop strobe
- data_out  out  DATA_WIDTH  registered external pop data
- irq  out  1  level interrupt

## Operation
- LW = $clog2(FIFO_DEPTH)+1 is the level width.
- Register map:
  - 0x000 CONTROL RW: [0] enable, [1] soft_clear (write-1 pulse, reads 0), [2] irq_en. Reset 0.
  - 0x004 STATUS RO: [0] empty, [1] full, [2] almost_empty, [3] almost_full, [8+:LW] level.
  - 0x008 THRESH RW: [15:0] af_th, reset FIFO_DEPTH-2; [31:16] ae_th, reset 2.
  - 0x00C ERROR W1C: [0] overflow, [1] underflow. Sticky. Reset 0.
  - 0x010 DATA: a write pushes WDATA; a read pops and returns the head.
- Any other address returns SLVERR (2'b10), reads return 0, and there is no side effect. Writes to STATUS return OKAY and are ignored.
- WSTRB applies to CONTROL, THRESH and ERROR. A DATA push writes the full word regardless of WSTRB.
- almost_full = level >= af_th. almost_empty = level <= ae_th. Comparisons are unsigned, with the level zero-extended to 16 bits.
- Push while full, from either source, drops the data and sets overflow.
- Pop while empty, from either source, sets underflow. A CSR read returns 0; data_out holds.
- A push and a pop in the same cycle on a full FIFO both succeed and the level is unchanged.
- A push and a pop in the same cycle on an empty FIFO: the push succeeds and the pop is an underflow.
- While enable=0, all pushes and pops are ignored, no flags change and CSR access still works. A DATA access returns OKAY and does nothing.
- soft_clear resets the pointers and level to 0 in the cycle after the write commit. It does not clear ERROR or CONTROL.
- irq = irq_en & (overflow | underflow | almost_full), registered.
- Write FSM: IDLE → ACCEPT → COMMIT → RESP → IDLE.
  - IDLE waits for AWVALID & WVALID together.
  - ACCEPT drives AWREADY and WREADY high for exactly one cycle and captures address and data.
  - COMMIT performs the register write. For a DATA push it stays in COMMIT while external wr_en is high.
  - RESP holds BVALID high until BREADY.
- Read FSM: IDLE → ACCEPT (ARREADY one cycle) → FETCH → RESP (RVALID until RREADY). For a DATA pop, FETCH stays while external rd_en is high.
- The read and write FSMs are independent. If both commit in the same cycle, both take effect; a soft_clear commit overrides any same-cycle push or pop.

## Timing
- Reset values: all READY/VALID 0, BRESP/RRESP 0, RDATA 0, data_out 0, irq 0. STATUS reads empty=1, almost_empty=1, level=0.
- AXI write, counting from the first cycle AWVALID & WVALID is high (cycle 0):
  - ready in cycle 1;
  - commit at the end of cycle 2;
  - BVALID from cycle 3 when uncontended.
- AXI read: ARREADY in cycle 1, RDATA/RVALID from cycle 3. STATUS reflects the state at the end of cycle 2.
- External push: the level updates one cycle after wr_en is sampled.
- External pop: data_out and the level update one cycle after rd_en is sampled.
- Flags and irq lag the event that sets them by one cycle.
- A W1C write takes effect at commit. If a clear and a same-cycle set hit the same bit, the set wins.
- ARESETn assertion mid-transaction: all FSMs return to IDLE immediately, VALID/READY drop, and FIFO contents are lost.

## Structure
- Package axi_csr_fifo_pkg holds:
  - register offset localparams;
  - CONTROL/ERROR bit indices;
  - RESP_OKAY and RESP_SLVERR;
  - write and read FSM state enums.
- Sub-module sync_fifo (DEPTH, WIDTH) has one push port and one pop port. Pointers are one bit wider than the address for full/empty detection. It provides head-data fall-through and a level output. The top muxes the CSR and external sources onto its single push and pop ports.

## Test plan
- Reset, then read STATUS → 0x0000_0005 (empty, almost_empty, level 0); irq=0.
- Enable, external push 1..5, read STATUS → level=5, empty=0, almost_empty=0, full=0.
- Enable with irq_en, push 17 words (DEPTH 16) via DATA → full=1, almost_full=1, ERROR=0x1, irq=1. Write ERROR 0x1 → ERROR reads 0x0; irq stays 1 while almost_full.
- Pop all 16 via DATA reads → values in push order; a 17th read → RDATA 0, ERROR=0x2.
- Hold wr_en high during an AXI DATA push → COMMIT stalls. BVALID appears only after wr_en drops, and the level counts both pushes.
- Read 0x020 → RRESP=2'b10, RDATA 0. Write soft_clear with level 5 → level 0, ERROR unchanged. Assert ARESETn low mid-RESP → BVALID drops the same cycle.

Source files
------------

// File: rtl/axi_csr_fifo_pkg.sv
// Shared constants and types for the AXI4-Lite CSR + FIFO subsystem.
package axi_csr_fifo_pkg;

  localparam int unsigned CSR_CONTROL = 32'h000;
  localparam int unsigned CSR_STATUS  = 32'h004;
  localparam int unsigned CSR_THRESH  = 32'h008;
  localparam int unsigned CSR_ERROR   = 32'h00C;
  localparam int unsigned CSR_DATA    = 32'h010;

  localparam int unsigned CTRL_ENABLE     = 0;
  localparam int unsigned CTRL_SOFT_CLEAR = 1;
  localparam int unsigned CTRL_IRQ_EN     = 2;

  localparam int unsigned ERR_OVERFLOW  = 0;
  localparam int unsigned ERR_UNDERFLOW = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WrIdle, WrAccept, WrCommit, WrResp} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdAccept, RdFetch, RdResp} rd_state_e;

  typedef enum logic [2:0] {
    RegControl, RegStatus, RegThresh, RegError, RegData, RegNone
  } csr_reg_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through head data and occupancy level.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr_q[AW-1:0]] <= push_data;
  end

  assign head  = mem[rptr_q[AW-1:0]];
  assign level = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  // Wrap bits differ with equal index: writer is a full lap ahead.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/axi_csr_fifo_top_v2.sv
// AXI4-Lite CSR block fronting a FIFO that is also reachable from an external strobe port.
module axi_csr_fifo_top_v2
  import axi_csr_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    irq
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = DATA_WIDTH / 8;

  function automatic csr_reg_e decode(input logic [ADDR_WIDTH-3:0] w);
    if (w == (ADDR_WIDTH-2)'(CSR_CONTROL >> 2)) return RegControl;
    if (w == (ADDR_WIDTH-2)'(CSR_STATUS >> 2))  return RegStatus;
    if (w == (ADDR_WIDTH-2)'(CSR_THRESH >> 2))  return RegThresh;
    if (w == (ADDR_WIDTH-2)'(CSR_ERROR >> 2))   return RegError;
    if (w == (ADDR_WIDTH-2)'(CSR_DATA >> 2))    return RegData;
    return RegNone;
  endfunction

  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  csr_reg_e              wreg_q, rreg_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, rdata_d, data_out_q;
  logic [SW-1:0]         wstrb_q;
  logic [1:0]            bresp_q, rresp_q, rresp_d;
  logic                  en_q, irq_en_q, irq_q;
  logic [15:0]           af_th_q, ae_th_q;
  logic [1:0]            err_q, err_set, err_clr;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [LW-1:0]         fifo_level;
  logic                  almost_full, almost_empty;
  logic                  wr_commit, rd_fire, csr_push, csr_pop, soft_clear;
  logic                  push_req, pop_req, push_ok, pop_ok;

  // A CSR DATA access waits while the external port is using the same FIFO side.
  assign wr_commit  = (wr_state_q == WrCommit) && !((wreg_q == RegData) && wr_en);
  assign rd_fire    = (rd_state_q == RdFetch) && !((rreg_q == RegData) && rd_en);
  assign csr_push   = wr_commit && (wreg_q == RegData);
  assign csr_pop    = rd_fire && (rreg_q == RegData);
  assign soft_clear = wr_commit && (wreg_q == RegControl) && wstrb_q[0]
                      && wdata_q[CTRL_SOFT_CLEAR];

  assign push_req = en_q && (wr_en || csr_push);
  assign pop_req  = en_q && (rd_en || csr_pop);
  assign pop_ok   = pop_req && !fifo_empty;
  assign push_ok  = push_req && (!fifo_full || pop_ok);
  assign fifo_push = push_ok;
  assign fifo_pop  = pop_ok;

  assign almost_full  = 16'(fifo_level) >= af_th_q;
  assign almost_empty = 16'(fifo_level) <= ae_th_q;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .clr       (soft_clear),
    .push      (fifo_push),
    .push_data (wr_en ? data_in : wdata_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WrIdle:   if (S_AXI_AWVALID && S_AXI_WVALID) wr_state_d = WrAccept;
      WrAccept: wr_state_d = WrCommit;
      WrCommit: if (wr_commit) wr_state_d = WrResp;
      WrResp:   if (S_AXI_BREADY) wr_state_d = WrIdle;
      default:  wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RdIdle:   if (S_AXI_ARVALID) rd_state_d = RdAccept;
      RdAccept: rd_state_d = RdFetch;
      RdFetch:  if (rd_fire) rd_state_d = RdResp;
      RdResp:   if (S_AXI_RREADY) rd_state_d = RdIdle;
      default:  rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    unique case (rreg_q)
      RegControl: begin
        rdata_d[CTRL_ENABLE] = en_q;
        rdata_d[CTRL_IRQ_EN] = irq_en_q;
      end
      RegStatus: begin
        rdata_d[0]      = fifo_empty;
        rdata_d[1]      = fifo_full;
        rdata_d[2]      = almost_empty;
        rdata_d[3]      = almost_full;
        rdata_d[8 +: LW] = fifo_level;
      end
      RegThresh: rdata_d[31:0] = {ae_th_q, af_th_q};
      RegError: begin
        rdata_d[ERR_OVERFLOW]  = err_q[ERR_OVERFLOW];
        rdata_d[ERR_UNDERFLOW] = err_q[ERR_UNDERFLOW];
      end
      RegData:  if (pop_ok) rdata_d = fifo_head;
      RegNone:  rresp_d = RESP_SLVERR;
      default:  rresp_d = RESP_SLVERR;
    endcase
  end

  always_comb begin
    err_set = '0;
    err_clr = '0;
    err_set[ERR_OVERFLOW]  = push_req && !push_ok;
    err_set[ERR_UNDERFLOW] = pop_req && !pop_ok;
    if (wr_commit && (wreg_q == RegError) && wstrb_q[0]) err_clr = wdata_q[1:0];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state_q <= WrIdle;
      wreg_q     <= RegNone;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      af_th_q    <= 16'(FIFO_DEPTH - 2);
      ae_th_q    <= 16'd2;
      err_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      if (wr_state_q == WrAccept) begin
        wreg_q  <= decode(S_AXI_AWADDR[ADDR_WIDTH-1:2]);
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_commit) begin
        bresp_q <= (wreg_q == RegNone) ? RESP_SLVERR : RESP_OKAY;
        if (wreg_q == RegControl && wstrb_q[0]) begin
          en_q     <= wdata_q[CTRL_ENABLE];
          irq_en_q <= wdata_q[CTRL_IRQ_EN];
        end
        if (wreg_q == RegThresh) begin
          if (wstrb_q[0]) af_th_q[7:0]  <= wdata_q[7:0];
          if (wstrb_q[1]) af_th_q[15:8] <= wdata_q[15:8];
          if (wstrb_q[2]) ae_th_q[7:0]  <= wdata_q[23:16];
          if (wstrb_q[3]) ae_th_q[15:8] <= wdata_q[31:24];
        end
      end
      err_q <= (err_q & ~err_clr) | err_set;
      irq_q <= irq_en_q && ((|err_q) || almost_full);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state_q <= RdIdle;
      rreg_q     <= RegNone;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      data_out_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      if (rd_state_q == RdAccept) rreg_q <= decode(S_AXI_ARADDR[ADDR_WIDTH-1:2]);
      if (rd_fire) begin
        rdata_q <= rdata_d;
        rresp_q <= rresp_d;
      end
      if (rd_en && pop_ok) data_out_q <= fifo_head;
    end
  end

  assign S_AXI_AWREADY = (wr_state_q == WrAccept);
  assign S_AXI_WREADY  = (wr_state_q == WrAccept);
  assign S_AXI_BVALID  = (wr_state_q == WrResp);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (rd_state_q == RdAccept);
  assign S_AXI_RVALID  = (rd_state_q == RdResp);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign data_out      = data_out_q;
  assign irq           = irq_q;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           wstrb_q};

endmodule
